// File: rtl/dmem_uart_loader.sv
`timescale 1ns/1ps
// Boot loader for the data memory init port. It reads a UART byte stream made of a 32-bit word count
// followed by that many little-endian words, writes each word, and then raises done.
module dmem_uart_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 4096
) (
  input  logic        i_clk,
  input  logic        i_rst_x,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic [3:0]  o_init_wen,
  output logic [31:0] o_init_addr,
  output logic [31:0] o_init_data,
  output logic        o_init_done,
  output logic [31:0] o_word_cnt,
  output logic        o_overflow
);

  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

  typedef enum logic [1:0] {S_HDR, S_DATA, S_DONE} state_e;

  state_e      state_q;
  logic [1:0]  byte_idx_q;
  logic [31:0] shift_q;
  logic [31:0] shift_d;
  logic [31:0] remaining_q;
  logic [31:0] word_cnt_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [3:0]  wen_q;
  logic        done_q;
  logic        ovf_q;

  // Each new byte enters at the top, so after four bytes the first one sits in [7:0].
  assign shift_d = {i_rx_data, shift_q[31:8]};

  // NOTE: every register below uses <= so all of them update from the same pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_x) begin
    if (!i_rst_x) begin
      state_q     <= S_HDR;
      byte_idx_q  <= 2'd0;
      shift_q     <= 32'h0;
      remaining_q <= 32'h0;
      word_cnt_q  <= 32'h0;
      addr_q      <= BASE_ADDR;
      data_q      <= 32'h0;
      wen_q       <= 4'h0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      wen_q <= 4'h0;
      case (state_q)
        S_HDR: begin
          if (i_rx_valid) begin
            shift_q    <= shift_d;
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              remaining_q <= shift_d;
              if (shift_d > MAX_W) ovf_q <= 1'b1;
              if (shift_d == 32'h0) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (i_rx_valid) begin
            shift_q    <= shift_d;
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              // word_cnt_q equals the write index until capacity is reached.
              if (word_cnt_q < MAX_W) begin
                wen_q      <= 4'hF;
                addr_q     <= BASE_ADDR + {word_cnt_q[29:0], 2'b00};
                data_q     <= shift_d;
                word_cnt_q <= word_cnt_q + 32'd1;
              end
              remaining_q <= remaining_q - 32'd1;
              if (remaining_q == 32'd1) state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done_q <= 1'b1;
        end
        default: state_q <= S_HDR;
      endcase
    end
  end

  assign o_init_wen  = wen_q;
  assign o_init_addr = addr_q;
  assign o_init_data = data_q;
  assign o_init_done = done_q;
  assign o_word_cnt  = word_cnt_q;
  assign o_overflow  = ovf_q;

endmodule

// File: doc/dmem_uart_loader.md
Name: dmem_uart_loader

Overview:
- Upstream feeder of the cached data memory's init port (`i_dmem_init_done/wen/addr/data`), which the top level currently ties off.
- Consumes a byte stream from a UART receiver and assembles little-endian 32-bit words.
- Writes the words into data memory through the init port, then asserts done to release the core and normal dmem traffic.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; bits [1:0] must be 0.
- MAX_WORDS, 4096, capacity in words; later words are consumed but not written.

Ports:
- i_clk, input, 1, system clock; all state updates on rising edge.
- i_rst_x, input, 1, asynchronous active-low reset.
- i_rx_valid, input, 1, one-cycle strobe: i_rx_data holds a received byte.
- i_rx_data, input, 8, received byte.
- o_init_wen, output, 4, byte write enables to dmem init port; 4'hF or 4'h0.
- o_init_addr, output, 32, byte address of the write; bits [1:0] always 0.
- o_init_data, output, 32, write data.
- o_init_done, output, 1, load complete; stays high until reset.
- o_word_cnt, output, 32, number of words written so far (saturates at MAX_WORDS).
- o_overflow, output, 1, sticky; set when the header count exceeded MAX_WORDS.

Behaviour:
- Reset (async assert, sync release):
  - o_init_wen=0, o_init_addr=BASE_ADDR, o_init_data=0, o_init_done=0, o_word_cnt=0, o_overflow=0.
  - State=S_HDR; byte index=0; remaining=0.
- Stream format:
  - Bytes 0..3: word count N, little-endian (byte0 = N[7:0]).
  - Then N words, each 4 bytes little-endian.
  - No trailer.
- States:
  - S_HDR: collect 4 bytes into N.
    - On the 4th byte: N==0 -> S_DONE; otherwise -> S_DATA with remaining=N.
    - If N>MAX_WORDS, set o_overflow in the same cycle.
  - S_DATA: shift bytes into a word buffer at byte index 0..3.
    - On byte index 3: if write index < MAX_WORDS, the next cycle drives o_init_wen=4'hF for exactly one cycle with:
      - o_init_addr = BASE_ADDR + 4*index
      - o_init_data = assembled word
    - o_word_cnt increments in that same cycle.
    - remaining decrements; when it reaches 0 -> S_DONE.
  - S_DONE: o_init_done=1 from the cycle after the last write pulse, or the cycle after the header when N==0. i_rx_valid is ignored.
- Latency: write pulse appears 1 cycle after the i_rx_valid carrying the word's 4th byte.
- Outside write pulses, o_init_wen=0; o_init_addr/o_init_data hold the last written values.
- Back-to-back: i_rx_valid may be high every cycle. A byte arriving in the same cycle as a write pulse is accepted. No backpressure exists.
- Words beyond MAX_WORDS are consumed byte-for-byte with no write pulse, and o_word_cnt stays at MAX_WORDS.
- Header count is 32-bit unsigned; remaining uses 32 bits, so there is no wrap.
- Reset asserted mid-load:
  - Everything returns to reset values immediately.
  - A partial word is discarded.
  - The next byte after release is header byte 0.
- o_init_done never deasserts except by reset.

Test Plan:
- Normal load:
  - Stimulus: reset, then bytes 02 00 00 00 | 78 56 34 12 | EF BE AD DE with 3-cycle gaps.
  - Required response: pulse1 wen=F addr=0x0 data=0x12345678; pulse2 wen=F addr=0x4 data=0xDEADBEEF; o_init_done=1 the cycle after pulse2; o_word_cnt=2.
- Empty load:
  - Stimulus: header 00 00 00 00.
  - Required response: no wen pulse; o_init_done=1 the cycle after the 4th valid; further bytes produce no writes.
- Back-to-back:
  - Stimulus: header 03 00 00 00 plus 12 data bytes 01..0C with valid every cycle.
  - Required response: data 0x04030201@0x0, 0x08070605@0x4, 0x0C0B0A09@0x8; each pulse exactly 1 cycle after its 4th byte.
- Overflow:
  - Stimulus: MAX_WORDS=2, header 03 00 00 00, words 0x11111111, 0x22222222, 0x33333333.
  - Required response: two pulses only; o_overflow=1 from the header's 4th byte; o_word_cnt=2; done after the 12th data byte.
- Reset mid-word:
  - Stimulus: after header 01 00 00 00 and bytes AA BB, pulse i_rst_x low; then send 01 00 00 00 44 33 22 11.
  - Required response: single write data=0x11223344 addr=0x0; no write of AA/BB.
- Base address:
  - Stimulus: BASE_ADDR=0x100, header 01 00 00 00, one word.
  - Required response: o_init_addr=0x100 during the pulse.
